// File: rtl/cic_pkg.sv
// ============================================================================
//  cic_pkg -- shared types and default parameters for the CIC sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package cic_pkg;

  localparam int CIC_DW     = 24;
  localparam int CIC_DIV_W  = 8;
  localparam int CIC_SETTLE = 4;
  localparam int DROP_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } cic_state_e;

endpackage

`default_nettype wire

// File: rtl/cic_strobe_gen.sv
// ============================================================================
//  cic_strobe_gen -- divided clock-enable strobe and sample register.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cic_strobe_gen #(
  parameter int DW    = 24,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DW-1:0]    adc_i,
  output logic             clken_o,
  output logic [DW-1:0]    tdata_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clken_q, clken_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic             wrap;

  // Counter parks at 0 whenever the sequencer is not actively running.
  always_comb begin
    wrap    = (cnt_q == div_q);
    cnt_d   = '0;
    clken_d = 1'b0;
    tdata_d = tdata_q;
    if (active_i) begin
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      clken_d = wrap;
      if (wrap) tdata_d = adc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      cnt_q   <= '0;
      clken_q <= 1'b0;
      tdata_q <= '0;
    end else begin
      if (start_i) div_q <= div_i;
      cnt_q   <= cnt_d;
      clken_q <= clken_d;
      tdata_q <= tdata_d;
    end
  end

  assign clken_o = clken_q;
  assign tdata_o = tdata_q;

endmodule

`default_nettype wire

// File: rtl/cic_seq.sv
// ============================================================================
//  cic_seq -- CIC filter sequencer: strobe, settle discard, output hold.
//  Optional: CIC_SEQ_DROP_CNT_EN enables the saturating drop counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cic_seq
  import cic_pkg::*;
#(
  parameter int DW     = CIC_DW,
  parameter int DIV_W  = CIC_DIV_W,
  parameter int SETTLE = CIC_SETTLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DIV_W-1:0]  div,
  input  logic [DW-1:0]     adc_in,
  output logic              cic_clken,
  output logic [DW-1:0]     cic_tdata,
  output logic              cic_tvalid,
  input  logic              cic_tready,
  input  logic [DW-1:0]     cic_dout,
  input  logic              cic_dvalid,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  cic_state_e    state_q, state_d;
  logic [7:0]    discard_q, discard_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;

  logic start, active, busy_w;
  logic evt, settle_evt, run_evt, settle_done;
  logic load, out_lost, in_lost;

  assign busy_w = (state_q != ST_IDLE);
  assign start  = (state_q == ST_IDLE) && run;
  // Strobes stop on the same edge that returns the FSM to IDLE.
  assign active = busy_w && run;

  cic_strobe_gen #(
    .DW    (DW),
    .DIV_W (DIV_W)
  ) u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .active_i (active),
    .div_i    (div),
    .adc_i    (adc_in),
    .clken_o  (cic_clken),
    .tdata_o  (cic_tdata)
  );

  assign evt         = cic_clken && cic_dvalid && busy_w;
  assign settle_evt  = evt && (state_q == ST_SETTLE);
  assign run_evt     = evt && (state_q == ST_RUN);
  assign settle_done = settle_evt && (discard_q == SETTLE_LAST);
  assign load        = run_evt && (!out_valid_q || out_ready);
  assign out_lost    = run_evt && out_valid_q && !out_ready;
  assign in_lost     = cic_clken && !cic_tready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!run)             state_d = ST_IDLE;
        else if (settle_done) state_d = ST_RUN;
      end
      ST_RUN:    if (!run) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    discard_d   = discard_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (start)           discard_d = '0;
    else if (settle_evt) discard_d = discard_q + 1'b1;
    if (load) begin
      out_data_d  = cic_dout;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (start)                    overrun_d = 1'b0;
    else if (out_lost || in_lost) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      discard_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef CIC_SEQ_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0]   drop_sum;

  // Both loss sources may fire together, so the sum can step by 2.
  always_comb begin
    drop_sum = {1'b0, drop_q} + {{DROP_W{1'b0}}, out_lost} + {{DROP_W{1'b0}}, in_lost};
    drop_d   = drop_q;
    if (start)                 drop_d = '0;
    else if (drop_sum[DROP_W]) drop_d = '1;
    else                       drop_d = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  assign cic_tvalid = cic_clken;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_w;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_cic_seq.sv
// ============================================================================
//  tb_cic_seq -- directed self-checking bench for cic_seq.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cic_seq;

  localparam int DW    = 24;
  localparam int DIV_W = 8;
`ifdef CIC_SEQ_DROP_CNT_EN
  localparam int EXP_DROP_B = 2;
  localparam int EXP_DROP_D = 1;
`else
  localparam int EXP_DROP_B = 0;
  localparam int EXP_DROP_D = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             run;
  logic [DIV_W-1:0] div;
  logic [DW-1:0]    adc_in;
  logic             cic_clken;
  logic [DW-1:0]    cic_tdata;
  logic             cic_tvalid;
  logic             cic_tready;
  logic [DW-1:0]    cic_dout;
  logic             cic_dvalid;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic [15:0]      drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] adc_last;
  logic [DW-1:0] dout_last;

  cic_seq #(.DW(DW), .DIV_W(DIV_W), .SETTLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .div        (div),
    .adc_in     (adc_in),
    .cic_clken  (cic_clken),
    .cic_tdata  (cic_tdata),
    .cic_tvalid (cic_tvalid),
    .cic_tready (cic_tready),
    .cic_dout   (cic_dout),
    .cic_dvalid (cic_dvalid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    adc_last  = adc_in;
    dout_last = cic_dout;
    @(posedge clk);
    #1;
    adc_in   = adc_in + 24'h000111;
    cic_dout = cic_dout + 24'h000001;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cic_clken && n < 64);
    if (!cic_clken) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  int n;
  int bad;

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    div        = 8'd3;
    adc_in     = 24'h000100;
    cic_tready = 1'b1;
    cic_dout   = 24'h000000;
    cic_dvalid = 1'b1;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",     busy,      0);
    chk("rst_clken",    cic_clken, 0);
    chk("rst_tvalid",   cic_tvalid,0);
    chk("rst_tdata",    cic_tdata, 0);
    chk("rst_out_data", out_data,  0);
    chk("rst_out_valid",out_valid, 0);
    chk("rst_overrun",  overrun,   0);
    chk("rst_drop",     drop_cnt,  0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // div=3: strobe every 4 cycles, 4 settle events dropped, 5th loaded
    run = 1'b1;
    tick();
    chk("start_busy",  busy,      1);
    chk("start_clken", cic_clken, 0);
    for (int k = 1; k <= 5; k++) begin
      wait_strobe(n);
      chk("period_div3", n, 4);
      chk("tdata_cap",   cic_tdata, adc_last);
      chk("tvalid_eq",   cic_tvalid, cic_clken);
      if (k == 5) chk("settle_no_out", out_valid, 0);
      cic_dout = 24'h000100 + 24'(k);
    end
    tick();
    chk("first_out_valid", out_valid, 1);
    chk("first_out_data",  out_data,  24'h000105);
    chk("first_overrun",   overrun,   0);

    // accept, then three events with out_ready low
    out_ready = 1'b1;
    tick();
    chk("accept_clear", out_valid, 0);
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_strobe(n);
      cic_dout = 24'h000200 + 24'(k);
    end
    tick();
    chk("hold_valid",   out_valid, 1);
    chk("hold_data",    out_data,  24'h000201);
    chk("hold_overrun", overrun,   1);
    chk("hold_drop",    drop_cnt,  EXP_DROP_B);

    // stop with pending output
    run = 1'b0;
    tick();
    chk("stop_busy",  busy,      0);
    chk("stop_clken", cic_clken, 0);
    bad = 0;
    repeat (6) begin
      tick();
      if (cic_clken !== 1'b0) bad++;
    end
    chk("idle_no_clken", bad,       0);
    chk("idle_valid",    out_valid, 1);
    chk("idle_data",     out_data,  24'h000201);
    chk("idle_overrun",  overrun,   1);
    out_ready = 1'b1;
    tick();
    chk("idle_accept", out_valid, 0);

    // div=0 rerun: strobe every cycle, continuous output
    div = 8'd0;
    run = 1'b1;
    tick();
    chk("rerun_overrun", overrun,  0);
    chk("rerun_drop",    drop_cnt, 0);
    tick();
    chk("div0_first_clken", cic_clken, 1);
    repeat (4) tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("div0_clken", cic_clken, 1);
      chk("div0_valid", out_valid, 1);
      chk("div0_data",  out_data,  dout_last);
    end
    chk("div0_overrun", overrun, 0);

    // div=2 then div changed to 7 mid-run; tready low at one strobe
    run = 1'b0;
    repeat (2) tick();
    div = 8'd2;
    run = 1'b1;
    tick();
    div = 8'd7;
    wait_strobe(n);
    chk("period_div2_a", n, 3);
    wait_strobe(n);
    chk("period_div2_b", n, 3);
    cic_tready = 1'b0;
    tick();
    cic_tready = 1'b1;
    chk("tready_overrun", overrun,  1);
    chk("tready_drop",    drop_cnt, EXP_DROP_D);
    wait_strobe(n);
    chk("period_div2_c", n, 2);
    wait_strobe(n);
    chk("period_div2_d", n, 3);

    // reach RUN with a held output, then async reset mid-cycle
    out_ready = 1'b0;
    wait_strobe(n);
    wait_strobe(n);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",      busy,      0);
    chk("arst_clken",     cic_clken, 0);
    chk("arst_tvalid",    cic_tvalid,0);
    chk("arst_tdata",     cic_tdata, 0);
    chk("arst_out_data",  out_data,  0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_overrun",   overrun,   0);
    chk("arst_drop",      drop_cnt,  0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
